// File: rtl/ssf_pkg.sv
// ssf_pkg: shared definitions for the ssf host-side stream logic.
//   - DW_DEFAULT : default sample/result width
//   - REQ_DATA   : req_in code asking for a fresh sample
//   - OE_VALID   : out_en code flagging a valid io_out word
//   - state_t    : host FSM encoding (IDLE=0, RUN=1, STARVED=2)
//   - sat_inc    : saturating increment for counters up to 32 bits wide
package ssf_pkg;

    localparam int DW_DEFAULT = 32;

    localparam logic [1:0] REQ_DATA = 2'd1;
    localparam logic [1:0] OE_VALID = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_STARVED = 2'd2
    } state_t;

    // Increments value unless it already equals the all-ones pattern of a
    // width-bit counter. Callers zero-extend into 32 bits and truncate back.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
        logic [31:0] max_val;
        if (width >= 32) max_val = '1;
        else             max_val = (32'd1 << width) - 32'd1;
        return (value >= max_val) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/ssf_sync_fifo.sv
// ssf_sync_fifo: single-clock FIFO with synchronous active-high reset.
//   clk, rst          : clock, synchronous reset (flushes pointers)
//   wr_en, wr_data    : write request and data (ignored when full unless
//                       a read happens on the same edge)
//   rd_en             : read request (ignored when empty)
//   rd_data           : FWFT=1 -> combinational head, 0 while empty
//                       FWFT=0 -> registered; loads the head on a read and
//                                 holds it otherwise, resets to 0
//   full, empty       : occupancy flags
module ssf_sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 16,
    parameter bit FWFT  = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_rd;
    logic         do_wr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign do_rd = rd_en && !empty;
    // A full FIFO still accepts a write when a read frees a slot on the same edge.
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define
    // which entries are meaningful, so clearing the array buys nothing.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    generate
        if (FWFT) begin : g_fwft
            assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
        end else begin : g_std
            logic [W-1:0] rd_q;
            always_ff @(posedge clk) begin
                if (rst)        rd_q <= '0;
                else if (do_rd) rd_q <= mem[rd_ptr[AW-1:0]];
            end
            assign rd_data = rd_q;
        end
    endgenerate

endmodule

// File: rtl/ssf_stream_host.sv
// ssf_stream_host: host-side feeder/collector for the ssf core array.
//   clk, rst          : clock, synchronous active-high reset
//   en                : service enable (0 = array requests/outputs ignored)
//   smp_data/valid/ready : upstream sample stream into the input FIFO
//   io_in             : registered sample bus to the array (staging register)
//   req_in            : array request code (REQ_DATA = take a sample)
//   io_out, out_en    : array result word and its enable code (OE_VALID)
//   res_data/valid/ready : result stream out of the FWFT result FIFO
//   underflow_cnt     : requests that found no staged sample (saturating)
//   overflow_cnt      : results dropped on a full result FIFO (saturating)
//   proto_err         : sticky, reserved code seen on req_in/out_en while en
//   state             : FSM state (IDLE=0, RUN=1, STARVED=2)
module ssf_stream_host
    import ssf_pkg::*;
#(
    parameter int DW        = DW_DEFAULT,
    parameter int IN_DEPTH  = 16,
    parameter int OUT_DEPTH = 16,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DW-1:0]    smp_data,
    input  logic             smp_valid,
    output logic             smp_ready,
    output logic [DW-1:0]    io_in,
    input  logic [1:0]       req_in,
    input  logic [DW-1:0]    io_out,
    input  logic [1:0]       out_en,
    output logic [DW-1:0]    res_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] underflow_cnt,
    output logic [CNT_W-1:0] overflow_cnt,
    output logic             proto_err,
    output logic [1:0]       state
);

    state_t st;
    logic   staged;
    logic   staged_nxt;
    logic   in_full;
    logic   in_empty;
    logic   in_pop;
    logic   res_full;
    logic   res_empty;
    logic   res_push;
    logic   res_pop;
    logic   req_hit;
    logic   oe_hit;
    logic   oe_drop;
    logic   proto_hit;

    assign req_hit   = en && (req_in == REQ_DATA);
    assign oe_hit    = en && (out_en == OE_VALID);
    assign proto_hit = en && ((req_in >= 2'd2) || (out_en >= 2'd2));

    // The staging register is the input FIFO's registered read port, so a
    // pop both refills io_in and frees a FIFO slot. Pop to fill an empty
    // stage, or to replace a staged sample the array is consuming now.
    assign in_pop = !in_empty && (!staged || req_hit);

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        staged_nxt = staged;
        if (in_pop)       staged_nxt = 1'b1;
        else if (req_hit) staged_nxt = 1'b0;
    end

    assign smp_ready = !in_full;

    ssf_sync_fifo #(
        .W     (DW),
        .DEPTH (IN_DEPTH),
        .FWFT  (1'b0)
    ) u_in_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (smp_valid && !in_full),
        .wr_data (smp_data),
        .rd_en   (in_pop),
        .rd_data (io_in),
        .full    (in_full),
        .empty   (in_empty)
    );

    // A full result FIFO only drops when the consumer is not popping.
    assign res_pop   = !res_empty && res_ready;
    assign oe_drop   = oe_hit && res_full && !res_ready;
    assign res_push  = oe_hit && !oe_drop;
    assign res_valid = !res_empty;

    ssf_sync_fifo #(
        .W     (DW),
        .DEPTH (OUT_DEPTH),
        .FWFT  (1'b1)
    ) u_res_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (res_push),
        .wr_data (io_out),
        .rd_en   (res_pop),
        .rd_data (res_data),
        .full    (res_full),
        .empty   (res_empty)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            st            <= ST_IDLE;
            staged        <= 1'b0;
            underflow_cnt <= '0;
            overflow_cnt  <= '0;
            proto_err     <= 1'b0;
        end else begin
            staged <= staged_nxt;

            // State tracks the staged flag as it will be after this edge.
            if (!en)             st <= ST_IDLE;
            else if (staged_nxt) st <= ST_RUN;
            else                 st <= ST_STARVED;

            if (req_hit && !staged)
                underflow_cnt <= CNT_W'(sat_inc(32'(underflow_cnt), CNT_W));
            if (oe_drop)
                overflow_cnt <= CNT_W'(sat_inc(32'(overflow_cnt), CNT_W));
            if (proto_hit)
                proto_err <= 1'b1;
        end
    end

    assign state = st;

endmodule
